// File: rtl/compare_pkg.sv
// ---------------------------------------------------------------------------
// compare_pkg
//   Shared types and constants for the comparator result filter.
//   - cmp_code_t       : 2-bit comparison result code
//   - CMP_EQ/LT/GT/NONE: code values
//   - cmp_filt_state_t : filter FSM state (INIT, STABLE, PEND)
//   - is_one_hot3      : true when exactly one of three flags is high
// ---------------------------------------------------------------------------
package compare_pkg;

    typedef logic [1:0] cmp_code_t;

    localparam cmp_code_t CMP_EQ   = 2'b00;
    localparam cmp_code_t CMP_LT   = 2'b01;
    localparam cmp_code_t CMP_GT   = 2'b10;
    localparam cmp_code_t CMP_NONE = 2'b11;

    typedef enum logic [1:0] {
        ST_INIT   = 2'b00,
        ST_STABLE = 2'b01,
        ST_PEND   = 2'b10
    } cmp_filt_state_t;

    // Odd parity rules out 0 and 2 high; the AND term rules out 3 high.
    function automatic logic is_one_hot3(input logic a, input logic b, input logic c);
        return (a ^ b ^ c) & ~(a & b & c);
    endfunction

endpackage

// File: rtl/compare_encode.sv
// ---------------------------------------------------------------------------
// compare_encode
//   Combinational conversion of the comparator flags into a result code.
//   Build option COMPARE_FILTER_ILLEGAL_CHK_EN:
//     defined   : non-one-hot flags encode to NONE and raise 'illegal'
//     undefined : priority GT > LT > EQ, all-zero gives NONE, 'illegal' is 0
//   Ports:
//     equal, less_than, greater_than : comparator flags (in)
//     code                           : encoded result (out, 2 bits)
//     illegal                        : flags were not one-hot (out)
// ---------------------------------------------------------------------------
module compare_encode
    import compare_pkg::*;
(
    input  logic       equal,
    input  logic       less_than,
    input  logic       greater_than,
    output logic [1:0] code,
    output logic       illegal
);

    always_comb begin
        code    = CMP_NONE;
        illegal = 1'b0;
`ifdef COMPARE_FILTER_ILLEGAL_CHK_EN
        if (is_one_hot3(equal, less_than, greater_than)) begin
            if (equal)          code = CMP_EQ;
            else if (less_than) code = CMP_LT;
            else                code = CMP_GT;
        end
        illegal = ~is_one_hot3(equal, less_than, greater_than);
`else
        if (greater_than)   code = CMP_GT;
        else if (less_than) code = CMP_LT;
        else if (equal)     code = CMP_EQ;
`endif
    end

endmodule

// File: rtl/compare_result_filter.sv
// ---------------------------------------------------------------------------
// compare_result_filter
//   Debounces the comparator result: a code must be sampled on STABLE_CYCLES
//   consecutive edges before it is committed to filt_state. Each commit is
//   issued as a change event and counted.
//
//   Handshake: event_valid rises with a commit and, together with
//   event_prev/event_curr, holds until an edge where event_ready is high.
//   A commit may land on that same drain edge, replacing the payload while
//   event_valid stays high; otherwise a commit waits for the slot to drain.
//
//   Parameters:
//     STABLE_CYCLES : samples needed to commit (1..255), default 4
//     CNT_W         : width of change_count, default 8
//   Ports:
//     clk, rst (async, active high)
//     equal, less_than, greater_than : comparator flags
//     clear        : sync clear of change_count and illegal_flag
//     filt_state   : committed code
//     event_valid, event_ready, event_prev, event_curr : change event
//     change_count : committed changes, saturating
//     illegal_flag : sticky non-one-hot indication
//     dbg_state    : FSM state (cmp_filt_state_t encoding)
//   Build option: COMPARE_FILTER_ILLEGAL_CHK_EN (see compare_encode).
// ---------------------------------------------------------------------------
module compare_result_filter
    import compare_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             equal,
    input  logic             less_than,
    input  logic             greater_than,
    input  logic             clear,
    output logic [1:0]       filt_state,
    output logic             event_valid,
    input  logic             event_ready,
    output logic [1:0]       event_prev,
    output logic [1:0]       event_curr,
    output logic [CNT_W-1:0] change_count,
    output logic             illegal_flag,
    output logic [1:0]       dbg_state
);

    localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);

    cmp_filt_state_t  state_q, state_d;
    cmp_code_t        filt_q, filt_d;
    cmp_code_t        cand_q, cand_d;
    cmp_code_t        prev_q, prev_d;
    cmp_code_t        curr_q, curr_d;
    logic [7:0]       stab_q, stab_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;

    logic [1:0]       raw_code;
    logic             raw_illegal;
    logic             slot_free;
    logic             commit;

    compare_encode u_encode (
        .equal        (equal),
        .less_than    (less_than),
        .greater_than (greater_than),
        .code         (raw_code),
        .illegal      (raw_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_INIT;
            filt_q    <= CMP_NONE;
            cand_q    <= CMP_NONE;
            prev_q    <= CMP_NONE;
            curr_q    <= CMP_NONE;
            stab_q    <= 8'd0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            filt_q    <= filt_d;
            cand_q    <= cand_d;
            prev_q    <= prev_d;
            curr_q    <= curr_d;
            stab_q    <= stab_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        filt_d    = filt_q;
        cand_d    = raw_code;
        prev_d    = prev_q;
        curr_d    = curr_q;
        stab_d    = stab_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;

        // Stability tracking: saturating at STAB_MAX also keeps a deferred
        // commit armed until the event slot frees up.
        if (raw_code != cand_q)    stab_d = 8'd1;
        else if (stab_q >= STAB_MAX) stab_d = STAB_MAX;
        else                       stab_d = stab_q + 8'd1;

        // The slot is usable when empty or when it drains on this edge.
        slot_free = (state_q != ST_PEND) || event_ready;

        // Commit is judged on the next-state candidate so that the commit
        // lands on the STABLE_CYCLES-th sample, not one edge later.
        commit = (stab_d == STAB_MAX) && (cand_d != CMP_NONE) &&
                 (cand_d != filt_q) && slot_free;

        if (commit) begin
            filt_d = cand_d;
            prev_d = filt_q;
            curr_d = cand_d;
        end

        case (state_q)
            ST_INIT, ST_STABLE: if (commit) state_d = ST_PEND;
            ST_PEND:            if (event_ready && !commit) state_d = ST_STABLE;
            default:            state_d = ST_INIT;
        endcase

        // Clear first, then count, so a same-edge commit leaves a count of 1.
        if (clear) cnt_d = '0;
        if (commit && (cnt_d != {CNT_W{1'b1}})) cnt_d = cnt_d + 1'b1;

        if (clear)       illegal_d = 1'b0;
        if (raw_illegal) illegal_d = 1'b1;
    end

    assign filt_state   = filt_q;
    assign event_valid  = (state_q == ST_PEND);
    assign event_prev   = prev_q;
    assign event_curr   = curr_q;
    assign change_count = cnt_q;
    assign illegal_flag = illegal_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_compare_result_filter.sv
// ---------------------------------------------------------------------------
// tb_compare_result_filter
//   Directed scenarios plus randomized traffic against a run-length reference
//   model. Drained event payloads are collected in exp_q (model) and obs_q
//   (DUT) and compared at the end of the random phase.
// ---------------------------------------------------------------------------
module tb_compare_result_filter;
    import compare_pkg::*;

    localparam int S     = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             equal, less_than, greater_than;
    logic             clear;
    logic [1:0]       filt_state;
    logic             event_valid;
    logic             event_ready;
    logic [1:0]       event_prev, event_curr;
    logic [CNT_W-1:0] change_count;
    logic             illegal_flag;
    logic [1:0]       dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [1:0] m_last, m_filt, m_prev, m_curr;
    logic       m_valid, m_illegal;
    int         m_run, m_cnt;

    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];

    compare_result_filter #(.STABLE_CYCLES(S), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .equal        (equal),
        .less_than    (less_than),
        .greater_than (greater_than),
        .clear        (clear),
        .filt_state   (filt_state),
        .event_valid  (event_valid),
        .event_ready  (event_ready),
        .event_prev   (event_prev),
        .event_curr   (event_curr),
        .change_count (change_count),
        .illegal_flag (illegal_flag),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // flags = {gt, lt, eq}
    function automatic logic [1:0] ref_encode(input logic [2:0] flags);
        int ones;
        ones = flags[0] + flags[1] + flags[2];
`ifdef COMPARE_FILTER_ILLEGAL_CHK_EN
        if (ones != 1) return CMP_NONE;
        if (flags[0])  return CMP_EQ;
        if (flags[1])  return CMP_LT;
        return CMP_GT;
`else
        if (flags[2]) return CMP_GT;
        if (flags[1]) return CMP_LT;
        if (flags[0]) return CMP_EQ;
        return CMP_NONE;
`endif
    endfunction

    task automatic model_reset();
        m_last = CMP_NONE; m_filt = CMP_NONE; m_prev = CMP_NONE; m_curr = CMP_NONE;
        m_valid = 1'b0; m_illegal = 1'b0; m_run = 0; m_cnt = 0;
    endtask

    // One clock: drive at negedge, advance model after the edge.
    task automatic step(input logic [2:0] flags, input logic rdy, input logic clr);
        logic       pre_v;
        logic [1:0] pre_p, pre_c, r;
        logic       drain, commit;
        @(negedge clk);
        pre_v = event_valid; pre_p = event_prev; pre_c = event_curr;
        equal = flags[0]; less_than = flags[1]; greater_than = flags[2];
        event_ready = rdy; clear = clr;
        @(posedge clk);
        #1;
        r = ref_encode(flags);
        if (r == m_last) m_run++;
        else begin m_last = r; m_run = 1; end
        drain  = m_valid && rdy;
        commit = (m_run >= S) && (m_last != CMP_NONE) && (m_last != m_filt) &&
                 (!m_valid || rdy);
        if (drain) exp_q.push_back({m_prev, m_curr});
        if (pre_v && rdy) obs_q.push_back({pre_p, pre_c});
        if (commit) begin
            m_prev = m_filt; m_curr = m_last; m_filt = m_last; m_valid = 1'b1;
        end else if (drain) begin
            m_valid = 1'b0;
        end
        if (clr) m_cnt = 0;
        if (commit && m_cnt < CMAX) m_cnt++;
`ifdef COMPARE_FILTER_ILLEGAL_CHK_EN
        if (clr) m_illegal = 1'b0;
        if ((flags[0] + flags[1] + flags[2]) != 1) m_illegal = 1'b1;
`endif
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; equal = 0; less_than = 0; greater_than = 0;
        clear = 0; event_ready = 0;
        model_reset();
        #12;
        n_cmp++;
        if ({filt_state, event_valid, event_prev, event_curr, change_count, illegal_flag}
            !== {CMP_NONE, 1'b0, CMP_NONE, CMP_NONE, 8'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs: got filt=%b v=%b p=%b c=%b cnt=%0d ill=%b want 11 0 11 11 0 0",
                     filt_state, event_valid, event_prev, event_curr, change_count, illegal_flag);
        end
        n_cmp++;
        if (dbg_state !== ST_INIT) begin
            n_err++; $display("FAIL reset_state: got %b want %b", dbg_state, ST_INIT);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lt_commit();
        for (int i = 1; i <= S; i++) begin
            step(3'b010, 1'b1, 1'b0);
            if (i == S - 1) begin
                n_cmp++;
                if (filt_state !== CMP_NONE || event_valid !== 1'b0) begin
                    n_err++; $display("FAIL lt_early: got filt=%b v=%b want 11 0", filt_state, event_valid);
                end
            end
        end
        n_cmp++;
        if ({filt_state, event_valid, event_prev, event_curr} !== {CMP_LT, 1'b1, CMP_NONE, CMP_LT}) begin
            n_err++; $display("FAIL lt_commit: got filt=%b v=%b p=%b c=%b want 01 1 11 01",
                              filt_state, event_valid, event_prev, event_curr);
        end
        n_cmp++;
        if (change_count !== 8'd1) begin
            n_err++; $display("FAIL lt_count: got %0d want 1", change_count);
        end
        step(3'b010, 1'b1, 1'b0);
        n_cmp++;
        if (event_valid !== 1'b0) begin
            n_err++; $display("FAIL lt_valid_drop: got %b want 0", event_valid);
        end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 3; i++) step(3'b100, 1'b1, 1'b0);
        for (int i = 0; i < S + 1; i++) begin
            step(3'b010, 1'b1, 1'b0);
        end
        n_cmp++;
        if ({filt_state, event_valid, change_count} !== {CMP_LT, 1'b0, 8'd1}) begin
            n_err++; $display("FAIL glitch: got filt=%b v=%b cnt=%0d want 01 0 1",
                              filt_state, event_valid, change_count);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < S; i++) step(3'b100, 1'b0, 1'b0);
        n_cmp++;
        if ({filt_state, event_valid, event_prev, event_curr} !== {CMP_GT, 1'b1, CMP_LT, CMP_GT}) begin
            n_err++; $display("FAIL bp_commit: got filt=%b v=%b p=%b c=%b want 10 1 01 10",
                              filt_state, event_valid, event_prev, event_curr);
        end
        for (int i = 0; i < S + 2; i++) step(3'b001, 1'b0, 1'b0);
        n_cmp++;
        if ({filt_state, event_valid, event_prev, event_curr} !== {CMP_GT, 1'b1, CMP_LT, CMP_GT}) begin
            n_err++; $display("FAIL bp_hold: got filt=%b v=%b p=%b c=%b want 10 1 01 10",
                              filt_state, event_valid, event_prev, event_curr);
        end
        step(3'b001, 1'b1, 1'b0);
        n_cmp++;
        if ({filt_state, event_valid, event_prev, event_curr, change_count}
            !== {CMP_EQ, 1'b1, CMP_GT, CMP_EQ, 8'd3}) begin
            n_err++; $display("FAIL bp_replace: got filt=%b v=%b p=%b c=%b cnt=%0d want 00 1 10 00 3",
                              filt_state, event_valid, event_prev, event_curr, change_count);
        end
        step(3'b001, 1'b1, 1'b0);
        n_cmp++;
        if (event_valid !== 1'b0 || filt_state !== CMP_EQ) begin
            n_err++; $display("FAIL bp_drain: got v=%b filt=%b want 0 00", event_valid, filt_state);
        end
    endtask

    task automatic test_illegal();
        step(3'b111, 1'b1, 1'b0);
        step(3'b001, 1'b1, 1'b0);
        n_cmp++;
        if ({illegal_flag, filt_state, event_valid} !== {m_illegal, m_filt, m_valid}) begin
            n_err++; $display("FAIL illegal_set: got ill=%b filt=%b v=%b want %b %b %b",
                              illegal_flag, filt_state, event_valid, m_illegal, m_filt, m_valid);
        end
`ifdef COMPARE_FILTER_ILLEGAL_CHK_EN
        n_cmp++;
        if (illegal_flag !== 1'b1 || filt_state !== CMP_EQ) begin
            n_err++; $display("FAIL illegal_sticky: got ill=%b filt=%b want 1 00", illegal_flag, filt_state);
        end
`endif
        step(3'b001, 1'b1, 1'b1);
        n_cmp++;
        if (illegal_flag !== 1'b0 || change_count !== 8'd0) begin
            n_err++; $display("FAIL illegal_clear: got ill=%b cnt=%0d want 0 0", illegal_flag, change_count);
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 260; k++) begin
            for (int i = 0; i < S; i++) step((k % 2 == 0) ? 3'b010 : 3'b100, 1'b1, 1'b0);
        end
        n_cmp++;
        if (change_count !== 8'd255 || 32'(change_count) !== m_cnt) begin
            n_err++; $display("FAIL saturation: got %0d want 255 (model %0d)", change_count, m_cnt);
        end
    endtask

    task automatic test_random();
        logic [2:0] flags;
        int         hold;
        int         cycles;
        cycles = 0;
        while (cycles < 3000) begin
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 2))
                    0:       flags = 3'b001;
                    1:       flags = 3'b010;
                    default: flags = 3'b100;
                endcase
            end else begin
                flags = 3'($urandom_range(0, 7));
            end
            hold = $urandom_range(1, 2 * S);
            for (int i = 0; i < hold; i++) begin
                step(flags, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
                cycles++;
                n_cmp++;
                if ({filt_state, event_valid, event_prev, event_curr, change_count, illegal_flag}
                    !== {m_filt, m_valid, m_prev, m_curr, 8'(m_cnt), m_illegal}) begin
                    n_err++;
                    $display("FAIL random@%0d: got filt=%b v=%b p=%b c=%b cnt=%0d ill=%b want %b %b %b %b %0d %b",
                             cycles, filt_state, event_valid, event_prev, event_curr, change_count,
                             illegal_flag, m_filt, m_valid, m_prev, m_curr, m_cnt, m_illegal);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL event_count: got %0d drained events want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL event_payload[%0d]: got %b want %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_event();
        logic [2:0] flags;
        step(3'b000, 1'b1, 1'b0);
        flags = (m_filt == CMP_LT) ? 3'b100 : 3'b010;
        for (int i = 0; i < S; i++) step(flags, 1'b0, 1'b0);
        n_cmp++;
        if (event_valid !== 1'b1) begin
            n_err++; $display("FAIL mid_pending: got v=%b want 1", event_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if ({filt_state, event_valid, event_prev, event_curr, change_count, illegal_flag, dbg_state}
            !== {CMP_NONE, 1'b0, CMP_NONE, CMP_NONE, 8'd0, 1'b0, ST_INIT}) begin
            n_err++;
            $display("FAIL mid_reset: got filt=%b v=%b p=%b c=%b cnt=%0d ill=%b st=%b want 11 0 11 11 0 0 00",
                     filt_state, event_valid, event_prev, event_curr, change_count, illegal_flag, dbg_state);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < S; i++) step(3'b001, 1'b1, 1'b0);
        n_cmp++;
        if ({filt_state, event_valid, event_prev, event_curr, change_count}
            !== {CMP_EQ, 1'b1, CMP_NONE, CMP_EQ, 8'd1}) begin
            n_err++; $display("FAIL post_reset_commit: got filt=%b v=%b p=%b c=%b cnt=%0d want 00 1 11 00 1",
                              filt_state, event_valid, event_prev, event_curr, change_count);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_lt_commit();
        test_glitch();
        test_backpressure();
        test_illegal();
        test_saturation();
        test_random();
        test_reset_mid_event();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
